i2c_target: RTL and testbench

Write-only I2C target (slave) receiver for the same two-wire bus our I2C controller drives. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs the address and each data byte by pulling SDA low, and presents each received byte to the fabric with a one-cycle strobe. It is used on-chip as the bus-side model/peripheral that terminates controller transactions (loopback testing and register-load targets).

---
 rtl/i2c_target.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target: write-only I2C target receiver.
// Oversamples SCL/SDA, detects START/STOP, matches a 7-bit address (write only),
// ACKs address and data bytes by pulling SDA low, and strobes each received byte.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority-free
// agreement filter on both lines (rejects 1-2 cycle pulses, +2 cycles latency).
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h1A
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers (reset to 1 = idle bus)
    // ------------------------------------------------------------------
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_line;
    logic       sda_line;

    // Two-flop synchronizers for the asynchronous bus lines
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_io};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // The synchronizer output is the newest tap of a 3-sample window; the two
    // history flops hold the older samples.
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;
    logic       scl_filt_d;
    logic       sda_filt_d;
    logic [2:0] scl_win;
    logic [2:0] sda_win;

    assign scl_win = {scl_hist_q, scl_sync_q[1]};
    assign sda_win = {sda_hist_q, sda_sync_q[1]};

    // Filtered level follows the window only when all three samples agree
    always_comb begin
        scl_filt_d = scl_filt_q;
        sda_filt_d = sda_filt_q;
        if (&scl_win) begin
            scl_filt_d = 1'b1;
        end else if (~|scl_win) begin
            scl_filt_d = 1'b0;
        end
        if (&sda_win) begin
            sda_filt_d = 1'b1;
        end else if (~|sda_win) begin
            sda_filt_d = 1'b0;
        end
    end

    // Sample history and held filtered level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_line = scl_filt_d;
    assign sda_line = sda_filt_d;
`else
    assign scl_line = scl_sync_q[1];
    assign sda_line = sda_sync_q[1];
`endif

    // ------------------------------------------------------------------
    // Edge / bus-condition detection
    // ------------------------------------------------------------------
    logic scl_prev_q;
    logic sda_prev_q;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    // Previous-cycle line values for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_line;
            sda_prev_q <= sda_line;
        end
    end

    // An SCL edge masks any simultaneous SDA change, so START/STOP need SCL
    // high in both the current and previous sample.
    assign scl_rise  = scl_line & ~scl_prev_q;
    assign scl_fall  = ~scl_line & scl_prev_q;
    assign start_det = scl_line & scl_prev_q & ~sda_line & sda_prev_q;
    assign stop_det  = scl_line & scl_prev_q & sda_line & ~sda_prev_q;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       drive_q, drive_d;
    logic       valid_q, valid_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       busy_q, busy_d;

    // FSM and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            drive_q   <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            drive_q   <= drive_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and output logic; bus events in priority order
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        drive_d   = drive_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        busy_d    = busy_q;

        if (scl_rise) begin
            case (state_q)
                ST_ADDR: begin
                    shift_d   = {shift_q[6:0], sda_line};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if ((shift_q[6:0] == ADDRESS) && !sda_line) begin
                            state_d = ST_ADDR_ACK;
                            start_d = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    shift_d   = {shift_q[6:0], sda_line};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        data_d  = {shift_q[6:0], sda_line};
                        valid_d = 1'b1;
                        state_d = ST_DATA_ACK;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // First fall opens the ACK window, second fall closes it
                    if (!drive_q) begin
                        drive_d = 1'b1;
                    end else begin
                        drive_d   = 1'b0;
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            drive_d   = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            drive_d = 1'b0;
            if (busy_q) begin
                stop_d = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    assign sda_io  = drive_q ? 1'b0 : 1'bz;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign start_o = start_q;
    assign stop_o  = stop_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed self-checking bench for i2c_target.
// Bus timing: SCL low 8 / high 8 cycles, SDA changes mid-low-phase.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda_bus;
    logic [7:0] data;
    logic       valid;
    logic       start;
    logic       stop;
    logic       busy;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    i2c_target #(.ADDRESS(7'h1A)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .scl_i   (scl),
        .sda_io  (sda_bus),
        .data_o  (data),
        .valid_o (valid),
        .start_o (start),
        .stop_o  (stop),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         valid_cnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         drv_cnt = 0;
    logic [7:0] last_data = 8'h00;

    // Pulse counters and target-drive monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            last_data = data;
        end
        if (start) start_cnt = start_cnt + 1;
        if (stop)  stop_cnt = stop_cnt + 1;
        if (sda_bus === 1'b0 && !sda_low) drv_cnt = drv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entry: SCL low 4 cycles into its phase, or bus idle
    task automatic bus_start();
        sda_low = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(6);
        sda_low = 1'b1;
        tick(6);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1;
        tick(4);
        scl = 1'b1;
        tick(6);
        sda_low = 1'b0;
        tick(6);
    endtask

    task automatic bus_bit(input logic b);
        sda_low = !b;
        tick(4);
        scl = 1'b1;
        tick(8);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic bus_ack(output logic ack);
        sda_low = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(4);
        ack = sda_bus;
        tick(4);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_ack(ack);
    endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // Data bit with a one-cycle SCL high glitch inside the low phase
    task automatic bus_bit_glitch(input logic b);
        sda_low = !b;
        tick(2);
        scl = 1'b1;
        tick(1);
        scl = 1'b0;
        tick(1);
        scl = 1'b1;
        tick(8);
        scl = 1'b0;
        tick(4);
    endtask
`endif

    initial begin
        logic ack;
        int   v0, s0, p0, d0;

        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(100);
        check_eq("rst_data", data, 8'h00);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_start", start, 1'b0);
        check_eq("rst_stop", stop, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sda_z", sda_bus, 1'b1);
        check_eq("idle_pulses", valid_cnt + start_cnt + stop_cnt + drv_cnt, 0);

        // Addressed write of 0xA5
        v0 = valid_cnt; s0 = start_cnt; p0 = stop_cnt;
        bus_start();
        send_byte(8'h34, ack);
        check_eq("wr_addr_ack", ack, 1'b0);
        check_eq("wr_start_cnt", start_cnt - s0, 1);
        check_eq("wr_busy_high", busy, 1'b1);
        send_byte(8'hA5, ack);
        check_eq("wr_data_ack", ack, 1'b0);
        check_eq("wr_valid_cnt", valid_cnt - v0, 1);
        check_eq("wr_data_seen", last_data, 8'hA5);
        check_eq("wr_busy_mid", busy, 1'b1);
        check_eq("wr_stop_pre", stop_cnt - p0, 0);
        bus_stop();
        check_eq("wr_stop_cnt", stop_cnt - p0, 1);
        check_eq("wr_busy_low", busy, 1'b0);
        check_eq("wr_data_hold", data, 8'hA5);

        // Wrong address: fully ignored
        v0 = valid_cnt; s0 = start_cnt; p0 = stop_cnt; d0 = drv_cnt;
        bus_start();
        send_byte(8'h36, ack);
        check_eq("bad_addr_nack", ack, 1'b1);
        check_eq("bad_busy", busy, 1'b0);
        send_byte(8'h5A, ack);
        check_eq("bad_data_nack", ack, 1'b1);
        bus_stop();
        check_eq("bad_pulses", (valid_cnt - v0) + (start_cnt - s0) + (stop_cnt - p0), 0);
        check_eq("bad_no_drive", drv_cnt - d0, 0);
        check_eq("bad_data_hold", data, 8'hA5);

        // Read request to our address: NACK and ignore
        v0 = valid_cnt; s0 = start_cnt; p0 = stop_cnt; d0 = drv_cnt;
        bus_start();
        send_byte(8'h35, ack);
        check_eq("rd_nack", ack, 1'b1);
        check_eq("rd_busy", busy, 1'b0);
        send_byte(8'h11, ack);
        bus_stop();
        check_eq("rd_pulses", (valid_cnt - v0) + (start_cnt - s0) + (stop_cnt - p0), 0);
        check_eq("rd_no_drive", drv_cnt - d0, 0);

        // Repeated START discards a partial byte
        v0 = valid_cnt; s0 = start_cnt; p0 = stop_cnt;
        bus_start();
        send_byte(8'h34, ack);
        bus_bit(1'b1);
        bus_bit(1'b1);
        bus_bit(1'b1);
        bus_start();
        send_byte(8'h34, ack);
        check_eq("rs_addr_ack", ack, 1'b0);
        send_byte(8'h3C, ack);
        bus_stop();
        check_eq("rs_start_cnt", start_cnt - s0, 2);
        check_eq("rs_valid_cnt", valid_cnt - v0, 1);
        check_eq("rs_data", data, 8'h3C);
        check_eq("rs_stop_cnt", stop_cnt - p0, 1);

        // Back-to-back data bytes 0x00 and 0xFF
        v0 = valid_cnt;
        bus_start();
        send_byte(8'h34, ack);
        send_byte(8'h00, ack);
        check_eq("b2b_zero_data", data, 8'h00);
        send_byte(8'hFF, ack);
        check_eq("b2b_ff_ack", ack, 1'b0);
        bus_stop();
        check_eq("b2b_valid_cnt", valid_cnt - v0, 2);
        check_eq("b2b_data", data, 8'hFF);

        // Reset during the address ACK while SDA is held low by the target
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(logic'((8'h34 >> i) & 8'h01));
        sda_low = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(4);
        check_eq("mack_driven", sda_bus, 1'b0);
        v0 = valid_cnt; s0 = start_cnt; p0 = stop_cnt;
        rst = 1'b1;
        #1;
        check_eq("mack_sda_z", sda_bus, 1'b1);
        check_eq("mack_busy", busy, 1'b0);
        tick(3);
        rst = 1'b0;
        tick(10);
        check_eq("mack_no_pulses", (valid_cnt - v0) + (start_cnt - s0) + (stop_cnt - p0), 0);
        bus_start();
        send_byte(8'h34, ack);
        check_eq("post_rst_ack", ack, 1'b0);
        send_byte(8'hC3, ack);
        bus_stop();
        check_eq("post_rst_start", start_cnt - s0, 1);
        check_eq("post_rst_valid", valid_cnt - v0, 1);
        check_eq("post_rst_data", data, 8'hC3);
        check_eq("post_rst_stop", stop_cnt - p0, 1);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // SCL glitch during a low data phase must not add a bit
        v0 = valid_cnt;
        bus_start();
        send_byte(8'h34, ack);
        bus_bit(1'b1);
        bus_bit(1'b0);
        bus_bit_glitch(1'b1);
        bus_bit(1'b0);
        bus_bit(1'b0);
        bus_bit(1'b1);
        bus_bit(1'b0);
        bus_bit(1'b1);
        bus_ack(ack);
        bus_stop();
        check_eq("glitch_valid_cnt", valid_cnt - v0, 1);
        check_eq("glitch_data", data, 8'hA5);
        check_eq("glitch_ack", ack, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
